// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core datapath.
// Holds the data-memory access-size encodings and the default widths that
// pipeline stages and helper blocks use for their parameters.
package mips_pkg;

  // Default datapath and register-index widths.
  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_REG_ADDR_WIDTH = 5;
  localparam int DEFAULT_CNT_WIDTH      = 32;

  // Access-size encodings, shared with data_memory.
  typedef enum logic [1:0] {
    MASK_WORD = 2'b00,
    MASK_3B   = 2'b01,
    MASK_HALF = 2'b10,
    MASK_BYTE = 2'b11
  } mask_e;

endpackage

// File: rtl/load_extend.sv
// Sub-word load extension (purely combinational).
// Ports:
//   i_mem_data  - read data from data memory, low bytes valid, upper bytes zero
//   i_mask      - access size (see mips_pkg::mask_e)
//   i_unsigned  - 1: zero-extend (data passes through unchanged), 0: sign-extend
//   o_ext_data  - extended word
// The debug path reuses this block to format memory peeks.
module load_extend
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic [1:0]            i_mask,
  input  logic                  i_unsigned,
  output logic [DATA_WIDTH-1:0] o_ext_data
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if leaves it unassigned and infers a latch.
    o_ext_data = i_mem_data;
    if (!i_unsigned) begin
      case (i_mask)
        MASK_BYTE: o_ext_data = {{(DATA_WIDTH-8){i_mem_data[7]}},  i_mem_data[7:0]};
        MASK_HALF: o_ext_data = {{(DATA_WIDTH-16){i_mem_data[15]}}, i_mem_data[15:0]};
        MASK_3B:   o_ext_data = {{(DATA_WIDTH-24){i_mem_data[23]}}, i_mem_data[23:0]};
        default:   o_ext_data = i_mem_data;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage.
// Registers the write-back value (link address, extended memory data or ALU
// result), drives the register-file write port and the forwarding unit, and
// keeps the retired-instruction counter and the sticky halt flag.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   i_stall, i_flush  - hold all registers / load a bubble (flush wins)
//   i_valid           - incoming slot holds a real instruction
//   i_reg_write, i_mem_to_reg, i_link, i_mask, i_unsigned, i_halt - control
//   i_mem_data, i_alu_result, i_pc_link, i_rd - data and destination
//   o_wb_data, o_wb_rd, o_wb_en - register-file write port
//   o_valid           - stage holds a real instruction
//   o_retired         - committed-instruction count (wraps)
//   o_halted          - sticky, a HALT has committed
// All outputs are registered; latency is one cycle.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
  parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic                      i_valid,
  input  logic                      i_reg_write,
  input  logic                      i_mem_to_reg,
  input  logic                      i_link,
  input  logic [1:0]                i_mask,
  input  logic                      i_unsigned,
  input  logic                      i_halt,
  input  logic [DATA_WIDTH-1:0]     i_mem_data,
  input  logic [DATA_WIDTH-1:0]     i_alu_result,
  input  logic [DATA_WIDTH-1:0]     i_pc_link,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd,
  output logic [DATA_WIDTH-1:0]     o_wb_data,
  output logic [REG_ADDR_WIDTH-1:0] o_wb_rd,
  output logic                      o_wb_en,
  output logic                      o_valid,
  output logic [CNT_WIDTH-1:0]      o_retired,
  output logic                      o_halted
);

  logic [DATA_WIDTH-1:0] ext_data;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  acc;

  // Extension only matters when memory data is the selected source, so the
  // i_mem_to_reg qualifier is handled by the source select below.
  load_extend #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extend (
    .i_mem_data (i_mem_data),
    .i_mask     (i_mask),
    .i_unsigned (i_unsigned),
    .o_ext_data (ext_data)
  );

  // Once halted, every incoming instruction becomes a bubble.
  assign acc = i_valid & ~i_flush & ~o_halted;

  always_comb begin
    sel_data = i_alu_result;
    if (i_link) begin
      sel_data = i_pc_link;
    end else if (i_mem_to_reg) begin
      sel_data = ext_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is in the sensitivity list so it acts at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wb_data <= '0;
      o_wb_rd   <= '0;
      o_wb_en   <= 1'b0;
      o_valid   <= 1'b0;
      o_retired <= '0;
      o_halted  <= 1'b0;
    end else if (i_flush) begin
      o_wb_data <= '0;
      o_wb_rd   <= '0;
      o_wb_en   <= 1'b0;
      o_valid   <= 1'b0;
    end else if (!i_stall) begin
      o_wb_data <= sel_data;
      o_wb_rd   <= i_rd;
      // r0 is hard-wired zero: never enable a write to it.
      o_wb_en   <= acc & i_reg_write & (i_rd != '0);
      o_valid   <= acc;
      if (acc) begin
        o_retired <= o_retired + CNT_WIDTH'(1);
      end
      if (acc & i_halt) begin
        o_halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven bench for mem_wb_stage, plus hand-written sequences
// for asynchronous reset and the halt/counter-wrap corner cases.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        i_stall, i_flush, i_valid, i_reg_write, i_mem_to_reg, i_link;
  logic [1:0]  i_mask;
  logic        i_unsigned, i_halt;
  logic [31:0] i_mem_data, i_alu_result, i_pc_link;
  logic [4:0]  i_rd;

  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_rd;
  logic        o_wb_en, o_valid, o_halted;
  logic [31:0] o_retired;

  // Second instance with a 2-bit counter so the wrap is reachable quickly.
  logic [31:0] s_wb_data;
  logic [4:0]  s_wb_rd;
  logic        s_wb_en, s_valid, s_halted;
  logic [1:0]  s_retired;

  int checks   = 0;
  int failures = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid(i_valid), .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg),
    .i_link(i_link), .i_mask(i_mask), .i_unsigned(i_unsigned), .i_halt(i_halt),
    .i_mem_data(i_mem_data), .i_alu_result(i_alu_result), .i_pc_link(i_pc_link),
    .i_rd(i_rd), .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd), .o_wb_en(o_wb_en),
    .o_valid(o_valid), .o_retired(o_retired), .o_halted(o_halted)
  );

  mem_wb_stage #(.CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid(i_valid), .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg),
    .i_link(i_link), .i_mask(i_mask), .i_unsigned(i_unsigned), .i_halt(i_halt),
    .i_mem_data(i_mem_data), .i_alu_result(i_alu_result), .i_pc_link(i_pc_link),
    .i_rd(i_rd), .o_wb_data(s_wb_data), .o_wb_rd(s_wb_rd), .o_wb_en(s_wb_en),
    .o_valid(s_valid), .o_retired(s_retired), .o_halted(s_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid, reg_write, mem_to_reg, link;
    logic [1:0]  mask;
    logic        uns, halt, stall, flush;
    logic [31:0] mem_data, alu, pc_link;
    logic [4:0]  rd;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic        e_en, e_valid;
    logic [31:0] e_ret;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic rw, input logic m2r,
                       input logic link, input logic [1:0] mask, input logic uns,
                       input logic halt, input logic stall, input logic flush,
                       input logic [31:0] mem_data, input logic [31:0] alu,
                       input logic [31:0] pc_link, input logic [4:0] rd);
    i_valid = valid; i_reg_write = rw; i_mem_to_reg = m2r; i_link = link;
    i_mask = mask; i_unsigned = uns; i_halt = halt; i_stall = stall;
    i_flush = flush; i_mem_data = mem_data; i_alu_result = alu;
    i_pc_link = pc_link; i_rd = rd;
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},    o_wb_data, 32'h0);
    check({tag, "_rd"},      {27'h0, o_wb_rd}, 32'h0);
    check({tag, "_en"},      {31'h0, o_wb_en}, 32'h0);
    check({tag, "_valid"},   {31'h0, o_valid}, 32'h0);
    check({tag, "_retired"}, o_retired, 32'h0);
    check({tag, "_halted"},  {31'h0, o_halted}, 32'h0);
  endtask

  initial begin
    //            v  rw m2r lk mask  u  h  st fl mem_data      alu           pc_link       rd     e_data        e_rd   en vl ret
    vecs[0]  = '{1, 1, 1, 0, 2'b11, 0, 0, 0, 0, 32'h000000F0, 32'h0,        32'h0,        5'd5,  32'hFFFFFFF0, 5'd5,  1, 1, 32'd1};
    vecs[1]  = '{1, 1, 1, 0, 2'b10, 1, 0, 0, 0, 32'h00008001, 32'h0,        32'h0,        5'd6,  32'h00008001, 5'd6,  1, 1, 32'd2};
    vecs[2]  = '{1, 1, 1, 0, 2'b10, 0, 0, 0, 0, 32'h00008001, 32'h0,        32'h0,        5'd7,  32'hFFFF8001, 5'd7,  1, 1, 32'd3};
    vecs[3]  = '{1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0,        32'h00001234, 32'h0,        5'd0,  32'h00001234, 5'd0,  0, 1, 32'd4};
    vecs[4]  = '{1, 1, 1, 0, 2'b01, 0, 0, 0, 0, 32'h00800000, 32'h0,        32'h0,        5'd8,  32'hFF800000, 5'd8,  1, 1, 32'd5};
    vecs[5]  = '{1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h80000000, 32'h0,        32'h0,        5'd9,  32'h80000000, 5'd9,  1, 1, 32'd6};
    vecs[6]  = '{1, 1, 0, 0, 2'b11, 0, 0, 0, 0, 32'h000000F0, 32'h00000055, 32'h0,        5'd10, 32'h00000055, 5'd10, 1, 1, 32'd7};
    vecs[7]  = '{0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0,        32'h00000077, 32'h0,        5'd11, 32'h00000077, 5'd11, 0, 0, 32'd7};
    vecs[8]  = '{1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0,        32'h00000099, 32'h0,        5'd12, 32'h00000099, 5'd12, 0, 1, 32'd8};
    vecs[9]  = '{1, 1, 1, 1, 2'b11, 0, 0, 0, 0, 32'h000000F0, 32'h00000011, 32'h00000040, 5'd31, 32'h00000040, 5'd31, 1, 1, 32'd9};
    vecs[10] = '{1, 1, 1, 0, 2'b11, 0, 0, 1, 0, 32'h000000F0, 32'h0000AAAA, 32'h00000080, 5'd3,  32'h00000040, 5'd31, 1, 1, 32'd9};
    vecs[11] = '{1, 1, 0, 0, 2'b00, 0, 0, 1, 0, 32'h0,        32'h0000BBBB, 32'h0,        5'd4,  32'h00000040, 5'd31, 1, 1, 32'd9};
    vecs[12] = '{0, 0, 0, 1, 2'b10, 1, 1, 1, 0, 32'h0,        32'h0000CCCC, 32'h00000100, 5'd2,  32'h00000040, 5'd31, 1, 1, 32'd9};
    vecs[13] = '{1, 1, 0, 0, 2'b00, 0, 0, 1, 1, 32'h0,        32'h00000005, 32'h0,        5'd4,  32'h00000000, 5'd0,  0, 0, 32'd9};
    vecs[14] = '{1, 1, 0, 0, 2'b00, 0, 0, 0, 1, 32'h0,        32'h00000005, 32'h0,        5'd4,  32'h00000000, 5'd0,  0, 0, 32'd9};
    vecs[15] = '{1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0,        32'h00000005, 32'h0,        5'd4,  32'h00000005, 5'd4,  1, 1, 32'd10};

    rst = 1'b1;
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    step();
    step();
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].valid, vecs[i].reg_write, vecs[i].mem_to_reg, vecs[i].link,
            vecs[i].mask, vecs[i].uns, vecs[i].halt, vecs[i].stall, vecs[i].flush,
            vecs[i].mem_data, vecs[i].alu, vecs[i].pc_link, vecs[i].rd);
      step();
      check($sformatf("v%0d_data", i),    o_wb_data, vecs[i].e_data);
      check($sformatf("v%0d_rd", i),      {27'h0, o_wb_rd}, {27'h0, vecs[i].e_rd});
      check($sformatf("v%0d_en", i),      {31'h0, o_wb_en}, {31'h0, vecs[i].e_en});
      check($sformatf("v%0d_valid", i),   {31'h0, o_valid}, {31'h0, vecs[i].e_valid});
      check($sformatf("v%0d_retired", i), o_retired, vecs[i].e_ret);
      check($sformatf("v%0d_halted", i),  {31'h0, o_halted}, 32'h0);
    end

    // Stall one cycle, then assert reset between edges while still stalled.
    drive(1, 1, 0, 0, 2'b00, 0, 0, 1, 0, 32'h0, 32'h00000123, 32'h0, 5'd9);
    step();
    check("stall_hold_data", o_wb_data, 32'h00000005);
    #2 rst = 1'b1;
    #1;
    check_zero("async_rst_stall");
    step();
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    rst = 1'b0;

    // Seven ADDs, then HALT retiring as the eighth instruction.
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0, 32'(i + 100), 32'h0, 5'(i + 1));
      step();
    end
    check("pre_halt_retired", o_retired, 32'd7);
    check("pre_halt_small_retired", {30'h0, s_retired}, 32'd3);
    check("pre_halt_data", o_wb_data, 32'd106);

    drive(1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    step();
    check("halt_retired", o_retired, 32'd8);
    check("halt_halted", {31'h0, o_halted}, 32'h1);
    check("halt_valid", {31'h0, o_valid}, 32'h1);
    check("halt_en", {31'h0, o_wb_en}, 32'h0);
    check("halt_small_wrap", {30'h0, s_retired}, 32'h0);
    check("halt_small_halted", {31'h0, s_halted}, 32'h1);

    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h00000042, 32'h0, 5'd2);
      step();
      check($sformatf("post_halt%0d_en", i),      {31'h0, o_wb_en}, 32'h0);
      check($sformatf("post_halt%0d_valid", i),   {31'h0, o_valid}, 32'h0);
      check($sformatf("post_halt%0d_retired", i), o_retired, 32'd8);
      check($sformatf("post_halt%0d_halted", i),  {31'h0, o_halted}, 32'h1);
    end

    // Reset asserted between edges mid-sequence clears everything at once.
    #2 rst = 1'b1;
    #1;
    check_zero("async_rst_halted");
    check("async_rst_small_halted", {31'h0, s_halted}, 32'h0);
    step();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
